csa_nibble_serial_sequencer: RTL and testbench
==============================================

Name: csa_nibble_serial_sequencer

Overview:
- Multi-cycle controller that performs a WIDTH-bit addition using the team's existing 4-bit carry select adder, one nibble per clock.
- Sits directly around that adder: upstream it slices the operands and drives the adder's a/b/cin inputs; downstream it consumes the adder's sum/cout, registers the carry between cycles and assembles the wide result.
- The adder itself stays outside this block and is purely combinational.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4. NIBBLES = WIDTH/4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request a new addition. Sampled only in IDLE or DONE.
- a  input  WIDTH  operand A, captured on the accepted start.
- b  input  WIDTH  operand B, captured on the accepted start.
- cin  input  1  carry-in, captured on the accepted start.
- add_a  output  4  nibble of A to the adder.
- add_b  output  4  nibble of B to the adder.
- add_cin  output  1  carry to the adder.
- add_sum  input  4  adder sum, combinational from add_a/add_b/add_cin.
- add_cout  input  1  adder carry-out.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result; held stable until the next accepted start.
- cout  output  1  final carry-out; held with sum.

Behaviour:
- Reset (async, active-high):
  - state=IDLE.
  - busy, done, sum, cout, add_a, add_b, add_cin, internal operand/carry registers and nibble counter all 0.
  - Applies immediately, including mid-RUN. The partial result is discarded and no done is produced.
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - Capture a, b into shift registers; carry_reg<=cin; cnt<=0; go to RUN. Operands change freely after this edge.
- RUN:
  - add_a=a_reg[3:0], add_b=b_reg[3:0], add_cin=carry_reg. These are combinational from registers, so the adder settles within the cycle.
  - Each edge: add_sum is written into result bits [4*cnt+3:4*cnt]; carry_reg<=add_cout; a_reg, b_reg shift right by 4; cnt<=cnt+1.
  - On the edge where cnt==NIBBLES-1: sum<=assembled result (including this nibble), cout<=add_cout, go to DONE.
- DONE: lasts exactly one cycle with done=1.
  - start=1: behaves as the IDLE start (back-to-back accepted, RUN next).
  - Otherwise go to IDLE.
- Latency: start sampled at edge E0 gives done=1 in the cycle after edge E0+NIBBLES. With WIDTH=16, done is high 4 clocks after the start edge.
- Throughput: one addition per NIBBLES+1 cycles when start is held high.
- start while in RUN is ignored. Operands are not re-captured and the running result is not disturbed.
- sum/cout:
  - Update only on the final RUN edge; they never show partial nibbles.
  - Keep their last value through IDLE and through the RUN of the next operation until its final edge.
- add_a/add_b/add_cin are 0 whenever state is not RUN.
- busy=1 exactly in RUN.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No saturation.

Optional Feature:
- Macro: CSA_SEQ_OVERFLOW_EN.
- Defined:
  - Adds output port ovf (1 bit), the signed two's-complement overflow.
  - On the final RUN edge, ovf <= add_cout ^ (add_a[3]^add_b[3]^add_sum[3]), i.e. carry-out of the MSB XOR carry-in to the MSB.
  - Held with sum; reset to 0.
- Not defined: no ovf port and no related logic; all other behaviour is identical.

Test Plan:
- WIDTH=16, a=0xFFFF, b=0x0001, cin=0, start pulse -> busy high 4 cycles, then done 1 cycle; sum=0x0000, cout=1; add_cin sequence 0,1,1,1.
- a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0; add_a sequence 4,3,2,1.
- start held high continuously with a=0x00FF, b=0x0F01, cin=0 -> sum=0x1000, cout=0; done every 5th cycle, with a new RUN starting immediately after each DONE.
- Start a=0xAAAA, b=0x5555; change a/b and pulse start during RUN -> second start ignored; sum=0xFFFF, cout=0 from the originally captured operands.
- Assert rst asynchronously mid-edge-cycle during the 2nd RUN nibble -> outputs 0 immediately, no done; then a fresh start 0x0001+0x0001 -> sum=0x0002.
- With CSA_SEQ_OVERFLOW_EN: 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1; 0xFFFF+0x0001 -> ovf=0, cout=1.

Source files
------------

// File: rtl/csa_nibble_serial_sequencer.sv
// Nibble-serial WIDTH-bit adder controller driving an external 4-bit carry select adder.
// Optional signed-overflow output is enabled by defining CSA_SEQ_OVERFLOW_EN.
module csa_nibble_serial_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CSA_SEQ_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic [WIDTH-1:0]   merged;
    logic               run;
    logic               final_edge;

    // Nibbles enter at the top and shift down, so after NIBBLES steps the
    // first nibble sits at bit 0 without any variable part-select.
    generate
        if (WIDTH == 4) begin : g_single
            assign merged = add_sum;
        end else begin : g_multi
            logic [WIDTH-5:0] result_q;
            logic [WIDTH-5:0] result_d;

            assign merged = {add_sum, result_q};

            always_comb begin
                result_d = result_q;
                if (run) begin
                    result_d = merged[WIDTH-1:4];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    result_q <= '0;
                end else begin
                    result_q <= result_d;
                end
            end
        end
    endgenerate

    assign run        = (state_q == S_RUN);
    assign final_edge = run && (cnt_q == LAST_CNT);

    assign add_a   = run ? a_q[3:0] : 4'h0;
    assign add_b   = run ? b_q[3:0] : 4'h0;
    assign add_cin = run ? carry_q  : 1'b0;
    assign busy    = run;
    assign done    = (state_q == S_DONE);
    assign sum     = sum_q;
    assign cout    = cout_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                carry_d = add_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (final_edge) begin
                    sum_d   = merged;
                    cout_d  = add_cout;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

`ifdef CSA_SEQ_OVERFLOW_EN
    logic ovf_q, ovf_d;

    // Carry out of the MSB xor carry into the MSB (recovered from the sum bit).
    always_comb begin
        ovf_d = ovf_q;
        if (final_edge) begin
            ovf_d = add_cout ^ (add_a[3] ^ add_b[3] ^ add_sum[3]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_csa_nibble_serial_sequencer.sv
// Scoreboard bench for csa_nibble_serial_sequencer (WIDTH=16) with a behavioural 4-bit adder.
// Exercises ovf as well when CSA_SEQ_OVERFLOW_EN is defined.
module tb_csa_nibble_serial_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic [3:0]  add_a, add_b, add_sum;
    logic        add_cin, add_cout;
    logic        busy, done, cout;
    logic [15:0] sum;
`ifdef CSA_SEQ_OVERFLOW_EN
    logic        ovf;
`endif

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    logic [15:0] last_sum = '0;

    always #5 clk = ~clk;

    // The external combinational adder this block sits around.
    assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    csa_nibble_serial_sequencer #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout)
`ifdef CSA_SEQ_OVERFLOW_EN
        ,
        .ovf      (ovf)
`endif
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no result pending");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result_sum", 32'(sum), 32'(e.s));
                chk("result_cout", 32'(cout), 32'(e.c));
`ifdef CSA_SEQ_OVERFLOW_EN
                chk("result_ovf", 32'(ovf), 32'(e.o));
`endif
                $display("done: sum=0x%04h cout=%0d", sum, cout);
            end
        end
    end

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                          input logic [15:0] es, input logic ec, input logic eo,
                          input logic [15:0] ea_seq, input logic [3:0] ecin_seq);
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        exp_q.push_back('{es, ec, eo});
        $display("op: a=0x%04h b=0x%04h cin=%0d expect sum=0x%04h cout=%0d", ta, tb_v, tc, es, ec);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        cin = 1'($urandom);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_done", 32'(done), 32'd0);
            chk("run_add_a", 32'(add_a), 32'(ea_seq[4*i +: 4]));
            chk("run_add_cin", 32'(add_cin), 32'(ecin_seq[i]));
            chk("run_sum_held", 32'(sum), 32'(last_sum));
        end
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_add_a", 32'(add_a), 32'd0);
        last_sum = es;
        @(negedge clk);
        chk("after_done", 32'(done), 32'd0);
        chk("after_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int dones;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_add", 32'({add_a, add_b, add_cin}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 4'b1110);
        run_op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 16'h1234, 4'b0001);

        // Start held high: three back-to-back operations, done every 5th cycle.
        @(negedge clk);
        a = 16'h00FF; b = 16'h0F01; cin = 1'b0; start = 1'b1;
        repeat (3) exp_q.push_back('{16'h1000, 1'b0, 1'b0});
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("held_done", 32'(done), 32'(i % 5 == 4));
            chk("held_busy", 32'(busy), 32'(i % 5 != 4));
            if (i == 14) start = 1'b0;
        end
        @(negedge clk);
        chk("held_idle", 32'({busy, done}), 32'd0);
        last_sum = 16'h1000;

        // A start during RUN must not re-capture operands.
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; cin = 1'b0; start = 1'b1;
        exp_q.push_back('{16'hFFFF, 1'b0, 1'b0});
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ignore_add_a", 32'(add_a), 32'hA);
        @(negedge clk);
        chk("ignore_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("ignore_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("ignore_idle", 32'({busy, done}), 32'd0);

        // Asynchronous reset in the second RUN nibble: outputs clear, no done.
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_sum", 32'(sum), 32'd0);
        chk("arst_cout", 32'(cout), 32'd0);
        chk("arst_add", 32'({add_a, add_b, add_cin}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_sum = '0;
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("arst_no_done", 32'(dones), 32'd0);
        run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 16'h0001, 4'b0000);

`ifdef CSA_SEQ_OVERFLOW_EN
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 16'h7FFF, 4'b1110);
        chk("ovf_set", 32'(ovf), 32'd1);
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 4'b1110);
        chk("ovf_clear", 32'(ovf), 32'd0);
`endif

        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
